// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package serial_add_ctrl_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder cell used as the serial datapath.
module serial_add_ctrl_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // Plain combinational sum and carry-out.
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: captures operands, runs one full-adder
// evaluation per cycle LSB first, then presents a registered result with a
// one-cycle done pulse.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic accept;
    logic fa_s, fa_co;

    // Start is honoured only outside RUN; a start in DONE chains straight into RUN.
    assign accept = start && (state_q != StRun);

    serial_add_ctrl_full_adder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == CntLast) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Datapath next-state: capture on accept, shift one bit per RUN cycle.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (accept) begin
            a_sh_d  = a;
            // Subtract as a + ~b + 1.
            b_sh_d  = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            cnt_d   = '0;
        end else if (state_q == StRun) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            carry_d = fa_co;
            if (cnt_q == CntLast) begin
                // Final bit: publish result; counter holds so it never wraps.
                sum_d  = res_d;
                cout_d = fa_co;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH = 8).
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } res_t;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    res_t         sb_q[$];
    vec_t         vecs[9];
    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        chk("busy_done_excl", 32'(busy & done), 32'd0);
        if (done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got sum=%0h with nothing expected", sum);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                last_sum  = e.s;
                last_cout = e.c;
            end
        end
    end

    // Drive one accepted start, then scramble inputs to prove they were captured.
    task automatic issue(input logic s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic [W-1:0] es, input logic ec,
                         input bit push);
        sub   = s;
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        if (push) sb_q.push_back('{s: es, c: ec});
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    // Check W busy cycles then the done cycle; optionally poke start mid-RUN.
    task automatic wait_done(input int poke_at);
        for (int i = 1; i <= W; i++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("sum_hold", 32'(sum), 32'(last_sum));
            if (i == poke_at) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
                sub   = 1'b0;
                cin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("done_latency", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{sub: 1'b0, a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1};
        vecs[1] = '{sub: 1'b1, a: 8'h05, b: 8'h07, cin: 1'b0, s: 8'hFE, c: 1'b0};
        vecs[2] = '{sub: 1'b1, a: 8'h07, b: 8'h05, cin: 1'b1, s: 8'h02, c: 1'b1};
        vecs[3] = '{sub: 1'b0, a: 8'h7F, b: 8'h00, cin: 1'b1, s: 8'h80, c: 1'b0};
        vecs[4] = '{sub: 1'b0, a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, c: 1'b0};
        vecs[5] = '{sub: 1'b0, a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1};
        vecs[6] = '{sub: 1'b1, a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b1};
        vecs[7] = '{sub: 1'b0, a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b0};
        vecs[8] = '{sub: 1'b1, a: 8'h80, b: 8'h01, cin: 1'b0, s: 8'h7F, c: 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of single operations, each returning to IDLE afterwards.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, 1'b1);
            wait_done(0);
            @(posedge clk);
            #1;
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_sum", 32'(sum), 32'(vecs[i].s));
        end

        // Start during RUN is ignored; original result still lands on time.
        issue(1'b0, 8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b1);
        wait_done(3);
        @(posedge clk);
        #1;
        chk("poke_no_rerun", 32'(busy), 32'd0);

        // Back-to-back: start in the DONE cycle goes straight back into RUN.
        issue(1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b1);
        wait_done(0);
        issue(1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);
        wait_done(0);
        @(posedge clk);
        #1;

        // Reset mid-RUN aborts with no done pulse.
        issue(1'b0, 8'h55, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            chk("pre_rst_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        last_sum  = '0;
        last_cout = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b1);
        wait_done(0);
        @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
